elink_mem_responder: RTL and testbench

//  Far-end (chip-side) responder for the elink parallel stream: decodes 72-bit beats (8 frame + 64 data,
//  as produced for the TX serializer), commits writes to an internal word memory, answers reads with

---
 rtl/elink_mem_responder_pkg.sv | 40 ++++
 rtl/elink_resp_fifo.sv | 52 +++++
 rtl/elink_mem_responder.sv | 192 +++++++++++++++++++
 tb/tb_elink_mem_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/elink_mem_responder_pkg.sv
// Shared elink packet definitions: frame codes, header/packet layouts, FSM state types.
package elink_mem_responder_pkg;

   localparam logic [7:0] FRAME_A = 8'hFF;
   localparam logic [7:0] FRAME_B = 8'hF8;
   localparam logic [1:0] DM_WORD = 2'b10;

   typedef struct packed {
      logic [3:0] ctrlmode;
      logic [1:0] datamode;
      logic       write;
      logic       access;
   } hdr_t;

   // Field order equals byte order on the wire: byte0, dstaddr, data, srcaddr
   typedef struct packed {
      hdr_t        hdr;
      logic [31:0] dstaddr;
      logic [31:0] data;
      logic [31:0] srcaddr;
   } pkt_t;

   localparam int PKT_W = $bits(pkt_t);

   typedef enum logic {
      RX_IDLE,
      RX_BEAT_B
   } rx_state_e;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_SEND_A,
      TX_SEND_B
   } tx_state_e;

   function automatic logic [63:0] beat_a(input pkt_t p);
      return {p.hdr, p.dstaddr, p.data[31:8]};
   endfunction

endpackage

// File: rtl/elink_resp_fifo.sv
// Synchronous FIFO for read responses; one-cycle push/pop, read data from head register array.
// Simultaneous push and pop allowed even when full; a push into a full FIFO without pop is ignored.
module elink_resp_fifo #(
   parameter int WIDTH = 104,
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == FULL_CNT);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/elink_mem_responder.sv
// Chip-side elink responder: decodes 2-beat packets, writes word memory, returns read responses.
// Read beat B at cycle t -> response beat A at t+3; tx_rd_wait holds new responses, rx_rd_wait throttles reads.
module elink_mem_responder
   import elink_mem_responder_pkg::*;
#(
   parameter int          ADDR_W     = 6,
   parameter logic [31:0] BASE_ADDR  = 32'h8080_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        lclk,
   input  logic        reset_n,
   input  logic [63:0] rx_data,
   input  logic [7:0]  rx_frame,
   input  logic        tx_rd_wait,
   output logic [63:0] tx_data,
   output logic [7:0]  tx_frame,
   output logic        rx_rd_wait,
   output logic        rx_wr_wait,
   output logic [7:0]  err_cnt,
   output logic        ovf
);
   localparam int               CNT_W       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] RD_WAIT_LVL = CNT_W'(FIFO_DEPTH - 2);

   rx_state_e          rx_state_q, rx_state_d;
   tx_state_e          tx_state_q, tx_state_d;
   logic [63:0]        beat_a_q, beat_a_d;
   logic               frame_err, beat_b_vld;
   pkt_t               req, push_pkt, head;
   logic               addr_hit, dec_ok, wr_en, rd_req, rx_err;
   logic [31:0]        mem_q [2**ADDR_W];
   logic               rd_vld_q;
   logic [ADDR_W-1:0]  rd_idx_q;
   logic [3:0]         rd_ctrl_q;
   logic [31:0]        rd_dst_q, rd_src_q;
   logic [PKT_W-1:0]   fifo_rdata;
   logic [CNT_W-1:0]   fifo_cnt;
   logic               fifo_full, fifo_empty, fifo_pop, push_ok, ovf_evt;
   logic [39:0]        tail_q, tail_d;
   logic [63:0]        tx_data_q, tx_data_d;
   logic [7:0]         tx_frame_q, tx_frame_d;
   logic               rx_rd_wait_q, ovf_q;
   logic [7:0]         err_cnt_q, err_cnt_d;
   logic [1:0]         err_inc;
   logic [8:0]         err_sum;
   logic               unused_ok;

   always_comb begin
      rx_state_d = rx_state_q;
      beat_a_d   = beat_a_q;
      frame_err  = 1'b0;
      beat_b_vld = 1'b0;
      case (rx_state_q)
         RX_BEAT_B: begin
            if (rx_frame == FRAME_B) begin
               beat_b_vld = 1'b1;
               rx_state_d = RX_IDLE;
            end else begin
               frame_err = 1'b1;
               // A fresh beat A restarts the packet instead of wasting it
               if (rx_frame == FRAME_A) beat_a_d = rx_data;
               else                     rx_state_d = RX_IDLE;
            end
         end
         default: begin
            if (rx_frame == FRAME_A) begin
               beat_a_d   = rx_data;
               rx_state_d = RX_BEAT_B;
            end else if (rx_frame != 8'h00) begin
               frame_err = 1'b1;
            end
         end
      endcase
   end

   assign req      = pkt_t'({beat_a_q, rx_data[63:24]});
   assign addr_hit = (req.dstaddr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
   assign dec_ok   = req.hdr.access && (req.hdr.datamode == DM_WORD) && addr_hit;
   assign wr_en    = reset_n && beat_b_vld && dec_ok && req.hdr.write;
   assign rd_req   = beat_b_vld && dec_ok && !req.hdr.write;
   assign rx_err   = frame_err || (beat_b_vld && !dec_ok);
   assign unused_ok = ^{rx_data[23:0], req.dstaddr[1:0]};

   always_ff @(posedge lclk) begin
      if (wr_en) mem_q[req.dstaddr[ADDR_W+1:2]] <= req.data;
   end

   always_comb begin
      push_pkt.hdr.ctrlmode = rd_ctrl_q;
      push_pkt.hdr.datamode = DM_WORD;
      push_pkt.hdr.write    = 1'b1;
      push_pkt.hdr.access   = 1'b1;
      push_pkt.dstaddr      = rd_src_q;
      push_pkt.data         = mem_q[rd_idx_q];
      push_pkt.srcaddr      = rd_dst_q;
   end

   assign push_ok = rd_vld_q && (!fifo_full || fifo_pop);
   assign ovf_evt = rd_vld_q && !push_ok;

   elink_resp_fifo #(
      .WIDTH (PKT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (lclk),
      .rst_ni  (reset_n),
      .push_i  (push_ok),
      .wdata_i (push_pkt),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .count_o (fifo_cnt),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign head = pkt_t'(fifo_rdata);

   always_comb begin
      tx_state_d = tx_state_q;
      tail_d     = tail_q;
      tx_data_d  = '0;
      tx_frame_d = '0;
      fifo_pop   = 1'b0;
      case (tx_state_q)
         TX_SEND_A: begin
            tx_state_d = TX_SEND_B;
            tx_data_d  = {tail_q, 24'h0};
            tx_frame_d = FRAME_B;
         end
         default: begin
            // IDLE and SEND_B share the start decision so responses can run back-to-back
            if (!fifo_empty && !tx_rd_wait) begin
               tx_state_d = TX_SEND_A;
               fifo_pop   = 1'b1;
               tail_d     = {head.data[7:0], head.srcaddr};
               tx_data_d  = beat_a(head);
               tx_frame_d = FRAME_A;
            end else begin
               tx_state_d = TX_IDLE;
            end
         end
      endcase
   end

   assign err_inc   = {1'b0, rx_err} + {1'b0, ovf_evt};
   assign err_sum   = {1'b0, err_cnt_q} + {7'b0, err_inc};
   assign err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];

   always_ff @(posedge lclk) begin
      if (!reset_n) begin
         rx_state_q   <= RX_IDLE;
         beat_a_q     <= '0;
         rd_vld_q     <= 1'b0;
         rd_idx_q     <= '0;
         rd_ctrl_q    <= '0;
         rd_dst_q     <= '0;
         rd_src_q     <= '0;
         tx_state_q   <= TX_IDLE;
         tail_q       <= '0;
         tx_data_q    <= '0;
         tx_frame_q   <= '0;
         rx_rd_wait_q <= 1'b0;
         err_cnt_q    <= '0;
         ovf_q        <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         beat_a_q   <= beat_a_d;
         rd_vld_q   <= rd_req;
         if (rd_req) begin
            rd_idx_q  <= req.dstaddr[ADDR_W+1:2];
            rd_ctrl_q <= req.hdr.ctrlmode;
            rd_dst_q  <= req.dstaddr;
            rd_src_q  <= req.srcaddr;
         end
         tx_state_q   <= tx_state_d;
         tail_q       <= tail_d;
         tx_data_q    <= tx_data_d;
         tx_frame_q   <= tx_frame_d;
         rx_rd_wait_q <= (fifo_cnt >= RD_WAIT_LVL);
         err_cnt_q    <= err_cnt_d;
         if (ovf_evt) ovf_q <= 1'b1;
      end
   end

   assign tx_data    = tx_data_q;
   assign tx_frame   = tx_frame_q;
   assign rx_rd_wait = rx_rd_wait_q;
   assign rx_wr_wait = 1'b0;
   assign err_cnt    = err_cnt_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_elink_mem_responder.sv
// Bench for elink_mem_responder: packet table, scoreboard of response beats, and corner-case sequences.
module tb_elink_mem_responder;

   logic        lclk = 1'b0;
   logic        reset_n = 1'b0;
   logic [63:0] rx_data = '0;
   logic [7:0]  rx_frame = '0;
   logic        tx_rd_wait = 1'b0;
   logic [63:0] tx_data;
   logic [7:0]  tx_frame;
   logic        rx_rd_wait, rx_wr_wait, ovf;
   logic [7:0]  err_cnt;

   int          checks = 0;
   int          failures = 0;
   int          exp_err = 0;
   bit          mon_en = 1'b1;
   logic [71:0] exp_q [$];

   typedef struct {
      logic [7:0]  b0;
      logic [31:0] dst;
      logic [31:0] data;
      logic [31:0] src;
      bit          resp;
      logic [31:0] rdata;
      int          err;
   } vec_t;
   vec_t vecs [12];

   always #5 lclk = ~lclk;

   elink_mem_responder dut (
      .lclk       (lclk),
      .reset_n    (reset_n),
      .rx_data    (rx_data),
      .rx_frame   (rx_frame),
      .tx_rd_wait (tx_rd_wait),
      .tx_data    (tx_data),
      .tx_frame   (tx_frame),
      .rx_rd_wait (rx_rd_wait),
      .rx_wr_wait (rx_wr_wait),
      .err_cnt    (err_cnt),
      .ovf        (ovf)
   );

   task automatic tick();
      @(posedge lclk);
      #1;
   endtask

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Drive one request packet; lanes 2..0 of beat B carry junk the responder must ignore
   task automatic send_pkt(input logic [7:0] b0, input logic [31:0] dst, input logic [31:0] data,
                           input logic [31:0] src);
      logic [103:0] p;
      p = {b0, dst, data, src};
      rx_frame = 8'hFF;
      rx_data  = p[103:40];
      tick();
      rx_frame = 8'hF8;
      rx_data  = {p[39:0], 24'hA5A5A5};
      tick();
      rx_frame = 8'h00;
      rx_data  = '0;
   endtask

   task automatic expect_resp(input logic [3:0] ctrl, input logic [31:0] req_dst,
                              input logic [31:0] data, input logic [31:0] req_src);
      logic [103:0] p;
      p = {ctrl, 2'b10, 1'b1, 1'b1, req_src, data, req_dst};
      exp_q.push_back({8'hFF, p[103:40]});
      exp_q.push_back({8'hF8, p[39:0], 24'h0});
   endtask

   task automatic wait_frame(input logic [7:0] f, input string name);
      int n;
      n = 0;
      while (tx_frame !== f && n < 20) begin
         tick();
         n++;
      end
      check(name, {64'h0, tx_frame}, {64'h0, f});
   endtask

   initial begin
      forever begin
         @(negedge lclk);
         if (mon_en && tx_frame !== 8'h00) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat actual=%h required=none", {tx_frame, tx_data});
            end else begin
               check("tx_beat", {tx_frame, tx_data}, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gaps;
      int n;

      vecs[0]  = '{8'h0B, 32'h8080_0000, 32'h1111_1111, 32'h0,          1'b0, 32'h0,          0};
      vecs[1]  = '{8'h0B, 32'h8080_00FC, 32'h2222_2222, 32'h0,          1'b0, 32'h0,          0};
      vecs[2]  = '{8'h39, 32'h8080_0000, 32'hFFFF_FFFF, 32'h8100_0004, 1'b1, 32'h1111_1111, 0};
      vecs[3]  = '{8'h09, 32'h8080_00FC, 32'h0,          32'h8100_0008, 1'b1, 32'h2222_2222, 0};
      vecs[4]  = '{8'h09, 32'h9000_0000, 32'h0,          32'h8100_000C, 1'b0, 32'h0,          1};
      vecs[5]  = '{8'h05, 32'h8080_0000, 32'h0,          32'h8100_0010, 1'b0, 32'h0,          1};
      vecs[6]  = '{8'h0A, 32'h8080_0000, 32'hBAD0_BAD0, 32'h0,          1'b0, 32'h0,          1};
      vecs[7]  = '{8'h09, 32'h8080_0000, 32'h0,          32'h8100_0014, 1'b1, 32'h1111_1111, 0};
      vecs[8]  = '{8'h0B, 32'h8080_0100, 32'h3333_3333, 32'h0,          1'b0, 32'h0,          1};
      vecs[9]  = '{8'h0B, 32'h8080_0008, 32'h4444_4444, 32'h0,          1'b0, 32'h0,          0};
      vecs[10] = '{8'h09, 32'h8080_0008, 32'h0,          32'h8100_0018, 1'b1, 32'h4444_4444, 0};
      vecs[11] = '{8'h08, 32'h8080_0008, 32'h0,          32'h8100_001C, 1'b0, 32'h0,          1};

      repeat (3) tick();
      check("rst_tx_frame", {64'h0, tx_frame}, 72'h0);
      check("rst_tx_data", {8'h0, tx_data}, 72'h0);
      check("rst_rx_rd_wait", {71'h0, rx_rd_wait}, 72'h0);
      check("rx_wr_wait", {71'h0, rx_wr_wait}, 72'h0);
      check("rst_err_cnt", {64'h0, err_cnt}, 72'h0);
      check("rst_ovf", {71'h0, ovf}, 72'h0);
      reset_n = 1'b1;
      tick();

      // Write then read with exact response timing
      send_pkt(8'h0B, 32'h8080_0010, 32'hDEAD_BEEF, 32'h0);
      repeat (2) tick();
      expect_resp(4'h0, 32'h8080_0010, 32'hDEAD_BEEF, 32'h8100_0000);
      send_pkt(8'h09, 32'h8080_0010, 32'h0, 32'h8100_0000);
      tick();
      check("lat_t2_idle", {64'h0, tx_frame}, 72'h0);
      tick();
      check("lat_t3_beat_a", {tx_frame, tx_data}, {8'hFF, 64'h0B81_0000_00DE_ADBE});
      tick();
      check("lat_beat_b", {tx_frame, tx_data}, {8'hF8, 64'hEF80_8000_1000_0000});
      tick();
      check("lat_idle_after", {tx_frame, tx_data}, 72'h0);

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].resp)
            expect_resp(vecs[i].b0[7:4], vecs[i].dst, vecs[i].rdata, vecs[i].src);
         send_pkt(vecs[i].b0, vecs[i].dst, vecs[i].data, vecs[i].src);
         exp_err += vecs[i].err;
         repeat (7) tick();
         check($sformatf("vec%0d_err_cnt", i), {64'h0, err_cnt}, 72'(exp_err));
         check($sformatf("vec%0d_drained", i), 72'(exp_q.size()), 72'h0);
      end

      // Beat A followed by an idle frame, then a stray frame code in idle
      rx_frame = 8'hFF; rx_data = 64'h0B80_8000_0000_0099;
      tick();
      rx_frame = 8'h00; rx_data = 64'h9900_0000_0000_0000;
      tick();
      rx_frame = 8'h0F;
      tick();
      rx_frame = 8'h00; rx_data = '0;
      exp_err += 2;
      repeat (4) tick();
      check("frame_err_cnt", {64'h0, err_cnt}, 72'(exp_err));

      // Two beat A in a row: first dropped, second completes as a read (memory unchanged)
      rx_frame = 8'hFF; rx_data = 64'h0B80_8000_0012_3456;
      tick();
      exp_err += 1;
      expect_resp(4'h0, 32'h8080_0000, 32'h1111_1111, 32'h8100_0030);
      send_pkt(8'h09, 32'h8080_0000, 32'h0, 32'h8100_0030);
      repeat (7) tick();
      check("restart_err_cnt", {64'h0, err_cnt}, 72'(exp_err));

      // Write, write, read of the same word with no gaps
      send_pkt(8'h0B, 32'h8080_0020, 32'h0101_0101, 32'h0);
      send_pkt(8'h0B, 32'h8080_0020, 32'hCAFE_F00D, 32'h0);
      expect_resp(4'h0, 32'h8080_0020, 32'hCAFE_F00D, 32'h8100_0020);
      send_pkt(8'h09, 32'h8080_0020, 32'h0, 32'h8100_0020);
      repeat (7) tick();
      check("raw_drained", 72'(exp_q.size()), 72'h0);

      // Fill the FIFO while the far end stalls, overflow it, then drain back-to-back
      tx_rd_wait = 1'b1;
      expect_resp(4'h0, 32'h8080_0000, 32'h1111_1111, 32'h8100_0040);
      send_pkt(8'h09, 32'h8080_0000, 32'h0, 32'h8100_0040);
      expect_resp(4'h0, 32'h8080_00FC, 32'h2222_2222, 32'h8100_0044);
      send_pkt(8'h09, 32'h8080_00FC, 32'h0, 32'h8100_0044);
      expect_resp(4'h0, 32'h8080_0008, 32'h4444_4444, 32'h8100_0048);
      send_pkt(8'h09, 32'h8080_0008, 32'h0, 32'h8100_0048);
      expect_resp(4'h0, 32'h8080_0020, 32'hCAFE_F00D, 32'h8100_004C);
      send_pkt(8'h09, 32'h8080_0020, 32'h0, 32'h8100_004C);
      repeat (3) tick();
      check("rd_wait_high", {71'h0, rx_rd_wait}, 72'h1);
      check("ovf_not_yet", {71'h0, ovf}, 72'h0);
      send_pkt(8'h09, 32'h8080_0010, 32'h0, 32'h8100_0050);
      repeat (3) tick();
      exp_err += 1;
      check("ovf_set", {71'h0, ovf}, 72'h1);
      check("ovf_err_cnt", {64'h0, err_cnt}, 72'(exp_err));
      check("stalled_no_tx", {64'h0, tx_frame}, 72'h0);
      tx_rd_wait = 1'b0;
      wait_frame(8'hFF, "drain_start");
      gaps = 0;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (tx_frame === 8'h00) gaps++;
      end
      check("no_gap", 72'(gaps), 72'h0);
      repeat (4) tick();
      check("ovf_drained", 72'(exp_q.size()), 72'h0);
      check("rd_wait_low", {71'h0, rx_rd_wait}, 72'h0);

      // Reset during beat B of a write: the write must be discarded
      rx_frame = 8'hFF; rx_data = 64'h0B80_8000_0877_7777;
      tick();
      rx_frame = 8'hF8; rx_data = 64'h7700_0000_0000_0000;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      rx_frame = 8'h00; rx_data = '0;
      exp_err = 0;
      check("rstb_tx_frame", {64'h0, tx_frame}, 72'h0);
      check("rstb_err_cnt", {64'h0, err_cnt}, 72'h0);
      check("rstb_ovf", {71'h0, ovf}, 72'h0);

      // Reset during SEND_A with another response still queued
      mon_en = 1'b0;
      tx_rd_wait = 1'b1;
      send_pkt(8'h09, 32'h8080_0000, 32'h0, 32'h8100_0060);
      send_pkt(8'h09, 32'h8080_00FC, 32'h0, 32'h8100_0064);
      repeat (2) tick();
      tx_rd_wait = 1'b0;
      wait_frame(8'hFF, "rsta_send_a");
      check("rsta_beat_a", {8'h0, tx_data}, {8'h0, 64'h0B81_0000_6011_1111});
      reset_n = 1'b0;
      tick();
      check("rsta_tx_frame", {64'h0, tx_frame}, 72'h0);
      check("rsta_tx_data", {8'h0, tx_data}, 72'h0);
      reset_n = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (tx_frame !== 8'h00) n++;
      end
      check("rsta_fifo_empty", 72'(n), 72'h0);
      mon_en = 1'b1;

      // Memory survives reset and the aborted write never landed
      expect_resp(4'h0, 32'h8080_0008, 32'h4444_4444, 32'h8100_0070);
      send_pkt(8'h09, 32'h8080_0008, 32'h0, 32'h8100_0070);
      expect_resp(4'h0, 32'h8080_0010, 32'hDEAD_BEEF, 32'h8100_0074);
      send_pkt(8'h09, 32'h8080_0010, 32'h0, 32'h8100_0074);

      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      repeat (4) tick();
      check("final_drain", 72'(exp_q.size()), 72'h0);
      check("final_err_cnt", {64'h0, err_cnt}, 72'(exp_err));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
